// File: rtl/uart_seq_pkg.sv
// Purpose: shared state encoding, command bytes and default timeout for the UART memory sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        TX_START,
        TX_GAP,
        TX_WAIT
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // 0.1 s at 50 MHz
    localparam int unsigned TIMEOUT_CYC_DEF = 5000000;

endpackage

// File: rtl/idle_timer.sv
// Purpose: idle-cycle counter; expired strobes in the CYCLES-th enabled cycle after the last clear.
// Latency: combinational strobe from the registered count.
// Backpressure: none; clear always wins over expiry.
module idle_timer #(
    parameter int unsigned CYCLES = 99
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = en && !clr && (cnt_q == CNT_W'(CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_mem_sequencer.sv
// Purpose: parse 'W'/'R' host frames from the UART and stream bytes into / out of the byte buffer.
// Latency: rx byte -> mem write 1 cycle; read issue -> tx_start 2 cycles; all outputs registered.
// Backpressure: read loop waits on tx_busy per byte; stalled frames abort after TIMEOUT_CYC idle cycles.
module uart_mem_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state_q, state_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   ptr_inc;
    logic [ADDR_W-1:0]   rx_len;
    logic                is_cmd;
    logic                timer_en, timer_clr, expired;

    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_raddr_q, mem_raddr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    assign is_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
    assign ptr_inc   = ptr_q + ADDR_W'(1);
    assign rx_len    = ADDR_W'({len_hi_q, rx_data});
    assign timer_en  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == WRITE);
    assign timer_clr = rx_valid || !timer_en;

    // err is registered one cycle after expiry, so the timer fires one cycle early
    idle_timer #(
        .CYCLES (TIMEOUT_CYC - 1)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cmd_wr_q <= 1'b0;
            len_hi_q <= '0;
            len_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_wr_q <= cmd_wr_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_wr_d = cmd_wr_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (rx_valid && is_cmd) begin
                    cmd_wr_d = (rx_data == CMD_WRITE);
                    ptr_d    = '0;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = LEN_LO;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d = rx_len;
                    if (rx_len == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = cmd_wr_q ? WRITE : RD_ISSUE;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (rx_valid) begin
                    ptr_d = ptr_inc;
                    if (ptr_inc == len_q) begin
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = TX_START;
            TX_START: state_d = TX_GAP;
            TX_GAP:   state_d = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy) begin
                    ptr_d   = ptr_inc;
                    state_d = (ptr_inc == len_q) ? IDLE : RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the transition being taken and registered below
    always_comb begin
        mem_we_d    = (state_q == WRITE) && rx_valid;
        mem_waddr_d = mem_we_d ? ptr_q : mem_waddr_q;
        mem_wdata_d = mem_we_d ? rx_data : mem_wdata_q;
        mem_re_d    = (state_d == RD_ISSUE);
        mem_raddr_d = mem_re_d ? ptr_d : mem_raddr_q;
        tx_start_d  = (state_d == TX_START);
        tx_data_d   = (state_q == RD_WAIT) ? mem_rdata : tx_data_q;
        busy_d      = (state_d != IDLE);
        err_d       = ((state_q == IDLE) && rx_valid && !is_cmd) || expired;
        done_d      = (state_q != IDLE) && (state_d == IDLE) && !expired;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= 8'h00;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_raddr_q <= mem_raddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_raddr = mem_raddr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Bench for uart_mem_sequencer: byte-buffer and transmitter models, event logger, scoreboarded frame tests.
module tb_uart_mem_sequencer;

    localparam int AW       = 16;
    localparam int TO       = 100;
    localparam int BUSY_CYC = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bcnt   = 0;

    always #5 clk = ~clk;

    uart_mem_sequencer #(
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Buffer and transmitter models
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr[7:0]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start)      bcnt <= BUSY_CYC;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    typedef struct { logic [AW-1:0] a; logic [7:0] d; logic dn; int c; } wr_ev_t;
    typedef struct { logic [7:0] d; int c; } tx_ev_t;
    typedef struct { logic [AW-1:0] a; int c; } re_ev_t;

    wr_ev_t     obs_wr[$];
    wr_ev_t     exp_wr[$];
    tx_ev_t     obs_tx[$];
    logic [7:0] exp_tx[$];
    re_ev_t     obs_re[$];
    int         obs_done[$];
    int         obs_err[$];
    int         both_cnt = 0;

    wr_ev_t log_w;
    tx_ev_t log_t;
    re_ev_t log_r;

    always @(negedge clk) begin
        if (mem_we) begin
            log_w.a = mem_waddr; log_w.d = mem_wdata; log_w.dn = done; log_w.c = cyc;
            obs_wr.push_back(log_w);
        end
        if (tx_start) begin
            log_t.d = tx_data; log_t.c = cyc;
            obs_tx.push_back(log_t);
        end
        if (mem_re) begin
            log_r.a = mem_raddr; log_r.c = cyc;
            obs_re.push_back(log_r);
        end
        if (done) obs_done.push_back(cyc);
        if (err)  obs_err.push_back(cyc);
        if (done && err) both_cnt++;
    end

    task automatic clear_obs();
        obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
        obs_re.delete(); obs_done.delete(); obs_err.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        c        = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_end(input int limit, input string name);
        int i;
        for (i = 0; i < limit; i++) begin
            if (obs_done.size() > 0 || obs_err.size() > 0) break;
            @(negedge clk); #1;
        end
        if (i == limit) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done/err within %0d cycles", name, limit);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d, input logic dn);
        wr_ev_t e;
        e.a = a; e.d = d; e.dn = dn; e.c = 0;
        exp_wr.push_back(e);
    endtask

    task automatic score_writes(input string name);
        wr_ev_t e, o;
        int n = exp_wr.size();
        for (int i = 0; i < n; i++) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin
                errors++;
                $display("FAIL %s_wr%0d: got no write, expected addr %h data %h", name, i, e.a, e.d);
            end else begin
                o = obs_wr.pop_front();
                if (o.a !== e.a || o.d !== e.d || o.dn !== e.dn) begin
                    errors++;
                    $display("FAIL %s_wr%0d: got a=%h d=%h done=%b, expected a=%h d=%h done=%b",
                             name, i, o.a, o.d, o.dn, e.a, e.d, e.dn);
                end
            end
        end
        checks++;
        if (obs_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_extra_writes: got %0d, expected 0", name, obs_wr.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle(3);
        checks++;
        if ({tx_start, tx_data, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tx_start=%b tx_data=%h we=%b waddr=%h re=%b raddr=%h busy=%b done=%b err=%b, expected all 0",
                     tx_start, tx_data, mem_we, mem_waddr, mem_re, mem_raddr, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        int c, c_first;
        clear_obs();
        push_wr(0, 8'hAA, 1'b0); push_wr(1, 8'hBB, 1'b0); push_wr(2, 8'hCC, 1'b1);
        send_byte(8'h57, c); send_byte(8'h00, c); send_byte(8'h03, c);
        send_byte(8'hAA, c_first); send_byte(8'hBB, c); send_byte(8'hCC, c);
        wait_end(20, "write");
        idle(3);
        checks++;
        if (obs_wr.size() == 0 || obs_wr[0].c != c_first + 1) begin
            errors++;
            $display("FAIL write_latency: got %0d, expected first write at cycle %0d",
                     (obs_wr.size() == 0) ? -1 : obs_wr[0].c, c_first + 1);
        end
        score_writes("write");
        checks++;
        if (obs_done.size() != 1 || obs_err.size() != 0) begin
            errors++;
            $display("FAIL write_strobes: got done=%0d err=%0d, expected 1 and 0", obs_done.size(), obs_err.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_read();
        int c;
        int s [3];
        tx_ev_t o;
        clear_obs();
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB); exp_tx.push_back(8'hCC);
        send_byte(8'h52, c); send_byte(8'h00, c); send_byte(8'h03, c);
        wait_end(200, "read");
        idle(3);
        checks++;
        if (obs_re.size() != 3 || obs_tx.size() != 3) begin
            errors++;
            $display("FAIL read_counts: got re=%0d tx=%0d, expected 3 and 3", obs_re.size(), obs_tx.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_re[i].a !== AW'(i)) begin
                    errors++;
                    $display("FAIL read_raddr%0d: got %h, expected %h", i, obs_re[i].a, AW'(i));
                end
            end
            checks++;
            if (obs_tx[0].c != obs_re[0].c + 2) begin
                errors++;
                $display("FAIL read_latency: got tx_start at %0d, expected %0d", obs_tx[0].c, obs_re[0].c + 2);
            end
            for (int i = 0; i < 3; i++) begin
                o = obs_tx.pop_front();
                s[i] = o.c;
                checks++;
                if (o.d !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL read_tx%0d: got %h, expected %h", i, o.d, exp_tx[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (s[i] - s[i-1] < BUSY_CYC + 1) begin
                    errors++;
                    $display("FAIL read_spacing%0d: got %0d, expected at least %0d", i, s[i] - s[i-1], BUSY_CYC + 1);
                end
            end
            checks++;
            if (obs_done.size() != 1 || obs_done[0] != s[2] + BUSY_CYC + 2) begin
                errors++;
                $display("FAIL read_done: got %0d pulses first at %0d, expected 1 at %0d",
                         obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, s[2] + BUSY_CYC + 2);
            end
        end
    endtask

    task automatic test_zero_len();
        int c;
        clear_obs();
        send_byte(8'h57, c); send_byte(8'h00, c); send_byte(8'h00, c);
        idle(4);
        checks++;
        if (obs_done.size() != 1 || obs_done[0] != c + 1 || obs_wr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: got done=%0d at %0d writes=%0d busy=%b, expected 1 at %0d, 0 writes, busy 0",
                     obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, obs_wr.size(), busy, c + 1);
        end
    endtask

    task automatic test_bad_cmd();
        int c, cb;
        clear_obs();
        send_byte(8'h41, cb);
        idle(3);
        checks++;
        if (obs_err.size() != 1 || obs_err[0] != cb + 1 || busy !== 1'b0 || obs_done.size() != 0) begin
            errors++;
            $display("FAIL bad_cmd: got err=%0d at %0d busy=%b done=%0d, expected 1 at %0d, busy 0, done 0",
                     obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : -1, busy, obs_done.size(), cb + 1);
        end
        obs_err.delete();
        push_wr(0, 8'h5A, 1'b1);
        send_byte(8'h57, c); send_byte(8'h00, c); send_byte(8'h01, c); send_byte(8'h5A, c);
        wait_end(20, "after_bad");
        idle(2);
        score_writes("after_bad");
        checks++;
        if (obs_err.size() != 0) begin
            errors++;
            $display("FAIL after_bad_err: got %0d err pulses, expected 0", obs_err.size());
        end
    endtask

    task automatic test_timeout();
        int c, t;
        clear_obs();
        push_wr(0, 8'h11, 1'b0);
        send_byte(8'h57, c); send_byte(8'h00, c); send_byte(8'h05, c); send_byte(8'h11, t);
        wait_end(TO + 50, "timeout");
        idle(3);
        checks++;
        if (obs_err.size() != 1 || obs_err[0] != t + TO || obs_done.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: got err=%0d at %0d done=%0d busy=%b, expected 1 at %0d, done 0, busy 0",
                     obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : -1, obs_done.size(), busy, t + TO);
        end
        score_writes("timeout");
        clear_obs();
        push_wr(0, 8'h77, 1'b1);
        send_byte(8'h57, c); send_byte(8'h00, c); send_byte(8'h01, c); send_byte(8'h77, c);
        wait_end(20, "restart");
        idle(2);
        score_writes("restart");
    endtask

    task automatic test_timeout_tie();
        int c, t;
        clear_obs();
        push_wr(0, 8'h22, 1'b0); push_wr(1, 8'h33, 1'b1);
        send_byte(8'h57, c); send_byte(8'h00, c); send_byte(8'h02, c); send_byte(8'h22, t);
        while (cyc < t + TO - 2) @(negedge clk);
        send_byte(8'h33, c);
        idle(5);
        checks++;
        if (c != t + TO - 1 || obs_err.size() != 0 || obs_done.size() != 1) begin
            errors++;
            $display("FAIL tie: got byte at %0d err=%0d done=%0d, expected byte at %0d, err 0, done 1",
                     c, obs_err.size(), obs_done.size(), t + TO - 1);
        end
        score_writes("tie");
    endtask

    task automatic test_reset_mid_read();
        int c, i;
        clear_obs();
        send_byte(8'h52, c); send_byte(8'h00, c); send_byte(8'h03, c);
        for (i = 0; i < 40; i++) begin
            if (obs_tx.size() > 0 && tx_busy) break;
            @(negedge clk); #1;
        end
        checks++;
        if (i == 40) begin
            errors++;
            $display("FAIL midread_start: got no tx_start with tx_busy high within 40 cycles");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midread_reset: got tx_start=%b busy=%b done=%b err=%b tx_busy=%b, expected 0 0 0 0 1",
                     tx_start, busy, done, err, tx_busy);
        end
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        checks++;
        if (obs_done.size() != 0 || obs_err.size() != 0) begin
            errors++;
            $display("FAIL midread_strobes: got done=%0d err=%0d, expected 0 and 0", obs_done.size(), obs_err.size());
        end
        clear_obs();
        send_byte(8'h52, c); send_byte(8'h00, c); send_byte(8'h01, c);
        wait_end(100, "reread");
        idle(2);
        checks++;
        if (obs_re.size() != 1 || obs_re[0].a !== '0 || obs_tx.size() != 1 || obs_tx[0].d !== 8'h22
            || obs_done.size() != 1) begin
            errors++;
            $display("FAIL reread: got re=%0d raddr=%h tx=%0d data=%h done=%0d, expected 1, 0000, 1, 22, 1",
                     obs_re.size(), (obs_re.size() > 0) ? obs_re[0].a : '1, obs_tx.size(),
                     (obs_tx.size() > 0) ? obs_tx[0].d : 8'hxx, obs_done.size());
        end
    endtask

    task automatic test_exclusive_strobes();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL done_err_overlap: got %0d cycles, expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_zero_len();
        test_bad_cmd();
        test_timeout();
        test_timeout_tie();
        test_reset_mid_read();
        test_exclusive_strobes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_mem_sequencer.md
# uart_mem_sequencer

Byte-level command controller between the UART receiver/transmitter pair and the on-chip byte buffer in the comm path. It parses framed host commands arriving on the receiver and handles two commands. A write command streams payload bytes into the buffer. A read command streams buffer contents back out through the transmitter, one byte per transmitter handshake. It owns the buffer write and read pointers and an inter-byte timeout that aborts stalled frames.

## Interface
Parameters:
- ADDR_W, 16, buffer address width; length field and pointers are ADDR_W bits.
- TIMEOUT_CYC, 5000000, maximum idle cycles between received bytes inside a frame (0.1 s at 50 MHz).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start.
- tx_start  out  1  one-cycle strobe: transmit tx_data.
- tx_data  out  8  byte to transmit; held stable until the next tx_start.
- mem_we  out  1  buffer write enable.
- mem_waddr  out  ADDR_W  buffer write address.
- mem_wdata  out  8  buffer write data.
- mem_re  out  1  buffer read enable.
- mem_raddr  out  ADDR_W  buffer read address.
- mem_rdata  in  8  buffer read data; valid one cycle after mem_re.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle strobe: frame completed.
- err  out  1  one-cycle strobe: bad command or timeout.

## Operation
- Frame format: CMD, LEN_HI, LEN_LO, then LEN payload bytes (write only). LEN is 16 bits, truncated to ADDR_W. CMD_WRITE = 8'h57 ('W'). CMD_READ = 8'h52 ('R').
- States: IDLE, LEN_HI, LEN_LO, WRITE, RD_ISSUE, RD_WAIT, TX_START, TX_GAP, TX_WAIT.
- IDLE: on rx_valid, a byte of 'W' or 'R' latches the command and moves to LEN_HI. Any other byte pulses err and stays in IDLE.
- LEN_HI to LEN_LO happens on rx_valid. On rx_valid in LEN_LO:
  - LEN == 0: pulse done, return to IDLE.
  - otherwise go to WRITE (write command) or RD_ISSUE (read command).
- The pointer resets to 0 at the start of every frame.
- WRITE: each rx_valid writes rx_data at the pointer, then increments the pointer. After byte LEN-1 is written, pulse done and go to IDLE.
- Read loop:
  - RD_ISSUE: mem_re=1, mem_raddr=pointer.
  - RD_WAIT: capture mem_rdata into tx_data.
  - TX_START: tx_start=1.
  - TX_GAP: ignore tx_busy for one cycle.
  - TX_WAIT: wait for tx_busy=0, then increment the pointer. If the pointer reaches LEN, pulse done and go to IDLE; otherwise go to RD_ISSUE.
- rx_valid received during any read-loop state is discarded with no error.
- Timeout: the idle counter clears on every rx_valid and on entry to LEN_HI. It counts in LEN_HI, LEN_LO and WRITE. At TIMEOUT_CYC it pulses err and goes to IDLE. Bytes already written stay in the buffer.
- The timeout is not active in the read loop.
- Pointer arithmetic is unsigned ADDR_W bits. LEN = 2^ADDR_W cannot occur because LEN_LO = 0 and LEN_HI = 0 means zero length.

## Timing
- Reset (asynchronous, reset=0): state IDLE, all outputs 0, pointers 0, tx_data 8'h00. Reset during a frame abandons it immediately with no done and no err.
- All outputs are registered.
- Write path: rx_valid in cycle n gives mem_we=1 with address and data in cycle n+1.
- Read path, per byte: RD_ISSUE in cycle n gives tx_start=1 in cycle n+2. The next RD_ISSUE comes no earlier than one cycle after tx_busy falls.
- done and err are each exactly one cycle wide and never asserted together.
- done for a write frame is asserted in the same cycle as the final mem_we.
- An rx_valid arriving in the same cycle as the timeout expires wins: the byte is processed and the counter clears.

## Structure
- Package uart_seq_pkg holds:
  - state enum state_t,
  - CMD_WRITE and CMD_READ,
  - default TIMEOUT_CYC.
- Sub-module idle_timer: a parameterised counter with inputs clear and enable and a one-cycle expired strobe. The top module contains the FSM and pointers.

## Test plan
- Write 'W',00,03,AA,BB,CC → mem_we three times with address/data 0/AA, 1/BB, 2/CC; done with the last write; busy low afterwards.
- Then 'R',00,03, with tx_busy held for 10 cycles per start → three tx_start pulses with tx_data AA, BB, CC; each start at least 11 cycles apart; done after the third busy falls.
- 'W',00,00 → done in the cycle after LEN_LO; no mem_we.
- Byte 8'h41 in IDLE → err for one cycle, state IDLE; a following 'W' frame proceeds normally.
- TIMEOUT_CYC=100: 'W',00,05,11 then silence → err exactly 100 cycles after byte 11; one write only; next frame restarts at address 0.
- reset pulled low mid-read while tx_busy=1 → tx_start=0, busy=0, no done; the next 'R' frame starts from address 0.
